// File: rtl/seqdet_stream_sched.sv
// seqdet_stream_sched: round-robin scheduler that time-shares one external
// Mealy sequence detector between NREQ requesters. A granted word is shifted
// into the detector MSB-first after a one-cycle flush, and the hit count is
// returned with the requester id over a valid/ready result port.
// Optional build macro: SEQDET_SCHED_FIRST_IDX_EN (reports first-hit bit index).
module seqdet_stream_sched #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 16,
  parameter int CNT_W  = $clog2(WORD_W + 1),
  parameter int IDX_W  = $clog2(WORD_W),
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WORD_W-1:0] req_word,
  output logic [NREQ-1:0]        req_ready,
  output logic                   det_rst,
  output logic                   det_din,
  input  logic                   det_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [CNT_W-1:0]       res_count,
  output logic [IDX_W-1:0]       res_first
);

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, REPORT} state_t;

  localparam logic [ID_W:0]    NREQ_W  = (ID_W + 1)'(NREQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(WORD_W - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    k_q;
  logic [WORD_W-1:0]   word_q;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W:0]       cand;
  logic [WORD_W-1:0]   sel_word;
  logic                accept;

  // Hit counter saturates rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin search from rr_q upward; lowest offset with a valid request wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      cand = {1'b0, rr_q} + (ID_W + 1)'(o);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Mux out the granted requester's word.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) sel_word = req_word[i*WORD_W +: WORD_W];
    end
  end

  // FSM next-state and detector/handshake outputs; reset overrides everything.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    det_rst   = 1'b1;
    det_din   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = FLUSH;
        end
      end
      FLUSH: state_d = SHIFT;
      SHIFT: begin
        det_rst = 1'b0;
        det_din = word_q[WORD_W-1];
        if (k_q == LAST_K) state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      state_d   = IDLE;
      req_ready = '0;
      det_rst   = 1'b1;
      det_din   = 1'b0;
      accept    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Scheduler control: rr pointer, served id, bit index and hit count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q  <= '0;
      id_q  <= '0;
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      if (accept) begin
        id_q  <= gnt_idx;
        rr_q  <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        cnt_q <= '0;
      end
      if (state_q == FLUSH) k_q <= '0;
      if (state_q == SHIFT) begin
        k_q <= k_q + 1'b1;
        if (det_y) cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  // Word shifter: MSB always presented on det_din during SHIFT.
  always_ff @(posedge clk) begin
    if (accept)                 word_q <= sel_word;
    else if (state_q == SHIFT)  word_q <= {word_q[WORD_W-2:0], 1'b0};
  end

  assign res_valid = (state_q == REPORT);
  assign res_id    = id_q;
  assign res_count = cnt_q;

`ifdef SEQDET_SCHED_FIRST_IDX_EN
  logic             hit_q;
  logic [IDX_W-1:0] first_q;

  // Latch the bit index of the first detection in the current word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      first_q <= '0;
    end else if (accept) begin
      hit_q   <= 1'b0;
      first_q <= '0;
    end else if (state_q == SHIFT && det_y && !hit_q) begin
      hit_q   <= 1'b1;
      first_q <= k_q;
    end
  end

  assign res_first = first_q;
`else
  assign res_first = '0;
`endif

endmodule
